// File: rtl/msp430_ram.sv
// Byte-addressable little-endian data RAM with word/byte access and 1-cycle registered reads.
// Optional macro RAM_RANGE_CHECK_EN adds a registered ram_err flag for out-of-range or misaligned word accesses.
module msp430_ram #(
    parameter logic [15:0] BASE_ADDR  = 16'h0200,
    parameter int          SIZE_BYTES = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        BW,
    input  logic        ram_RW,
    input  logic [15:0] ram_addr,
    input  logic [15:0] ram_Din,
`ifdef RAM_RANGE_CHECK_EN
    output logic        ram_err,
`endif
    output logic [15:0] ram_out
);

    localparam int          AW       = $clog2(SIZE_BYTES);
    localparam logic [16:0] END_EXCL = 17'(BASE_ADDR) + 17'(SIZE_BYTES);

    logic [7:0]    mem_q [SIZE_BYTES];
    logic [15:0]   ram_out_q;
    logic [15:0]   ram_out_d;
    logic          in_range;
    logic [AW-1:0] off;
    logic [AW-1:0] off_even;
    logic [AW-1:0] off_odd;

    // 17-bit compare so a window ending at 16'hFFFF never wraps
    assign in_range = ({1'b0, ram_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, ram_addr} < END_EXCL);
    assign off      = AW'(ram_addr - BASE_ADDR);
    assign off_even = {off[AW-1:1], 1'b0};
    assign off_odd  = {off[AW-1:1], 1'b1};

    always_comb begin
        ram_out_d = ram_out_q;
        if (!ram_RW) begin
            if (!in_range)
                ram_out_d = 16'h0000;
            else if (BW)
                ram_out_d = {8'h00, mem_q[off]};
            else
                ram_out_d = {mem_q[off_odd], mem_q[off_even]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SIZE_BYTES; i++)
                mem_q[i] <= 8'h00;
            ram_out_q <= 16'h0000;
        end else begin
            ram_out_q <= ram_out_d;
            if (ram_RW && in_range) begin
                if (BW) begin
                    mem_q[off] <= ram_Din[7:0];
                end else begin
                    mem_q[off_even] <= ram_Din[7:0];
                    mem_q[off_odd]  <= ram_Din[15:8];
                end
            end
        end
    end

    assign ram_out = ram_out_q;

`ifdef RAM_RANGE_CHECK_EN
    logic ram_err_q;

    always_ff @(posedge clk) begin
        if (rst)
            ram_err_q <= 1'b0;
        else
            ram_err_q <= !in_range || (!BW && ram_addr[0]);
    end

    assign ram_err = ram_err_q;
`endif

endmodule

// File: tb/tb_msp430_ram.sv
// Directed self-checking bench for msp430_ram; ram_err checks compile in only with RAM_RANGE_CHECK_EN.
module tb_msp430_ram;

    logic        clk;
    logic        rst;
    logic        BW;
    logic        ram_RW;
    logic [15:0] ram_addr;
    logic [15:0] ram_Din;
    logic [15:0] ram_out;
`ifdef RAM_RANGE_CHECK_EN
    logic        ram_err;
`endif

    int errors = 0;
    int checks = 0;

    msp430_ram dut (
        .clk      (clk),
        .rst      (rst),
        .BW       (BW),
        .ram_RW   (ram_RW),
        .ram_addr (ram_addr),
        .ram_Din  (ram_Din),
`ifdef RAM_RANGE_CHECK_EN
        .ram_err  (ram_err),
`endif
        .ram_out  (ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one access for one rising edge, then settle 1 time unit past the edge.
    task automatic access(input logic rw, input logic bw, input logic [15:0] addr, input logic [15:0] din);
        ram_RW   = rw;
        BW       = bw;
        ram_addr = addr;
        ram_Din  = din;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        access(1'b0, 1'b0, 16'h0200, 16'h0000);
        rst = 1'b0;
        access(1'b1, 1'b0, 16'h0206, 16'h1111);
        access(1'b0, 1'b0, 16'h0206, 16'h0000);
        checks++;
        if (ram_out !== 16'h1111) begin
            errors++;
            $display("FAIL pre_reset_read got=%h exp=%h", ram_out, 16'h1111);
        end
        rst = 1'b1;
        access(1'b1, 1'b0, 16'h0208, 16'h2222);
        checks++;
        if (ram_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out got=%h exp=%h", ram_out, 16'h0000);
        end
        rst = 1'b0;
        access(1'b0, 1'b0, 16'h0206, 16'h0000);
        checks++;
        if (ram_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_clears_mem got=%h exp=%h", ram_out, 16'h0000);
        end
        access(1'b0, 1'b0, 16'h0208, 16'h0000);
        checks++;
        if (ram_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_blocks_write got=%h exp=%h", ram_out, 16'h0000);
        end
        access(1'b0, 1'b0, 16'h0200, 16'h0000);
        checks++;
        if (ram_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_read_0200 got=%h exp=%h", ram_out, 16'h0000);
        end
    endtask

    task automatic test_word_rw();
        access(1'b1, 1'b0, 16'h0200, 16'hFFFF);
        access(1'b0, 1'b0, 16'h0200, 16'h0000);
        checks++;
        if (ram_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL word_read_0200 got=%h exp=%h", ram_out, 16'hFFFF);
        end
        access(1'b1, 1'b0, 16'h0202, 16'h1234);
        checks++;
        if (ram_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL write_holds_out got=%h exp=%h", ram_out, 16'hFFFF);
        end
        access(1'b0, 1'b0, 16'h0202, 16'h0000);
        checks++;
        if (ram_out !== 16'h1234) begin
            errors++;
            $display("FAIL word_read_0202 got=%h exp=%h", ram_out, 16'h1234);
        end
        access(1'b0, 1'b1, 16'h0203, 16'h0000);
        checks++;
        if (ram_out !== 16'h0012) begin
            errors++;
            $display("FAIL byte_read_0203 got=%h exp=%h", ram_out, 16'h0012);
        end
        access(1'b0, 1'b1, 16'h0202, 16'h0000);
        checks++;
        if (ram_out !== 16'h0034) begin
            errors++;
            $display("FAIL byte_read_0202 got=%h exp=%h", ram_out, 16'h0034);
        end
    endtask

    task automatic test_byte_merge();
        access(1'b1, 1'b0, 16'h0204, 16'hAAAA);
        access(1'b1, 1'b1, 16'h0205, 16'hEE55);
        access(1'b0, 1'b0, 16'h0204, 16'h0000);
        checks++;
        if (ram_out !== 16'h55AA) begin
            errors++;
            $display("FAIL byte_merge_hi got=%h exp=%h", ram_out, 16'h55AA);
        end
        access(1'b1, 1'b1, 16'h0204, 16'h9977);
        access(1'b0, 1'b0, 16'h0204, 16'h0000);
        checks++;
        if (ram_out !== 16'h5577) begin
            errors++;
            $display("FAIL byte_merge_lo got=%h exp=%h", ram_out, 16'h5577);
        end
    endtask

    task automatic test_out_of_range();
        access(1'b1, 1'b0, 16'h0400, 16'hBEEF);
        access(1'b1, 1'b0, 16'h01FE, 16'hBEEF);
        access(1'b0, 1'b0, 16'h0200, 16'h0000);
        checks++;
        if (ram_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL oor_no_alias got=%h exp=%h", ram_out, 16'hFFFF);
        end
        access(1'b0, 1'b0, 16'h0400, 16'h0000);
        checks++;
        if (ram_out !== 16'h0000) begin
            errors++;
            $display("FAIL oor_read_0400 got=%h exp=%h", ram_out, 16'h0000);
        end
        access(1'b0, 1'b0, 16'h0200, 16'h0000);
        access(1'b0, 1'b0, 16'h01FE, 16'h0000);
        checks++;
        if (ram_out !== 16'h0000) begin
            errors++;
            $display("FAIL oor_read_01FE got=%h exp=%h", ram_out, 16'h0000);
        end
        access(1'b0, 1'b1, 16'h0202, 16'h0000);
        access(1'b0, 1'b1, 16'h01FF, 16'h0000);
        checks++;
        if (ram_out !== 16'h0000) begin
            errors++;
            $display("FAIL oor_byte_01FF got=%h exp=%h", ram_out, 16'h0000);
        end
        access(1'b0, 1'b0, 16'h0200, 16'h0000);
        access(1'b0, 1'b0, 16'hFFFF, 16'h0000);
        checks++;
        if (ram_out !== 16'h0000) begin
            errors++;
            $display("FAIL oor_read_FFFF got=%h exp=%h", ram_out, 16'h0000);
        end
    endtask

    task automatic test_boundary();
        access(1'b1, 1'b0, 16'h03FE, 16'hC3A5);
        access(1'b0, 1'b0, 16'h03FE, 16'h0000);
        checks++;
        if (ram_out !== 16'hC3A5) begin
            errors++;
            $display("FAIL top_word got=%h exp=%h", ram_out, 16'hC3A5);
        end
        access(1'b0, 1'b1, 16'h03FF, 16'h0000);
        checks++;
        if (ram_out !== 16'h00C3) begin
            errors++;
            $display("FAIL top_byte got=%h exp=%h", ram_out, 16'h00C3);
        end
        access(1'b0, 1'b0, 16'h03FF, 16'h0000);
        checks++;
        if (ram_out !== 16'hC3A5) begin
            errors++;
            $display("FAIL misaligned_read got=%h exp=%h", ram_out, 16'hC3A5);
        end
        access(1'b1, 1'b0, 16'h0209, 16'hBEAD);
        access(1'b0, 1'b0, 16'h0208, 16'h0000);
        checks++;
        if (ram_out !== 16'hBEAD) begin
            errors++;
            $display("FAIL misaligned_write got=%h exp=%h", ram_out, 16'hBEAD);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] addr;
        logic [15:0] exp;
        for (int i = 0; i < 8; i++) begin
            addr = 16'h0220 + 16'(2 * i);
            exp  = (i < 4) ? 16'hFFFF : 16'h00FF;
            access(1'b1, (i >= 4), addr, 16'hFFFF);
            access(1'b0, (i >= 4), addr, 16'h0000);
            checks++;
            if (ram_out !== exp) begin
                errors++;
                $display("FAIL sweep_%0d addr=%h got=%h exp=%h", i, addr, ram_out, exp);
            end
        end
        access(1'b0, 1'b1, 16'h0229, 16'h0000);
        checks++;
        if (ram_out !== 16'h0000) begin
            errors++;
            $display("FAIL sweep_odd_untouched got=%h exp=%h", ram_out, 16'h0000);
        end
    endtask

`ifdef RAM_RANGE_CHECK_EN
    task automatic test_range_err();
        access(1'b0, 1'b0, 16'h0201, 16'h0000);
        checks++;
        if (ram_err !== 1'b1 || ram_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL err_misaligned got=%b/%h exp=1/%h", ram_err, ram_out, 16'hFFFF);
        end
        access(1'b0, 1'b0, 16'h0200, 16'h0000);
        checks++;
        if (ram_err !== 1'b0) begin
            errors++;
            $display("FAIL err_aligned got=%b exp=0", ram_err);
        end
        access(1'b0, 1'b1, 16'h0201, 16'h0000);
        checks++;
        if (ram_err !== 1'b0) begin
            errors++;
            $display("FAIL err_byte_odd got=%b exp=0", ram_err);
        end
        access(1'b1, 1'b0, 16'h01FE, 16'h1234);
        checks++;
        if (ram_err !== 1'b1) begin
            errors++;
            $display("FAIL err_oor_write got=%b exp=1", ram_err);
        end
        access(1'b0, 1'b1, 16'h0400, 16'h0000);
        checks++;
        if (ram_err !== 1'b1) begin
            errors++;
            $display("FAIL err_oor_read got=%b exp=1", ram_err);
        end
        access(1'b0, 1'b0, 16'h0202, 16'h0000);
        checks++;
        if (ram_err !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle got=%b exp=0", ram_err);
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        BW       = 1'b0;
        ram_RW   = 1'b0;
        ram_addr = 16'h0000;
        ram_Din  = 16'h0000;
        @(negedge clk);
        test_reset();
        test_word_rw();
        test_byte_merge();
        test_out_of_range();
        test_boundary();
        test_sweep();
`ifdef RAM_RANGE_CHECK_EN
        test_range_err();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msp430_ram.md
Name: msp430_ram

Overview:
- Byte-addressable data RAM for the MSP430 core model; sits on the memory data bus beside ROM and the peripheral space.
- Supports word (16-bit) and byte (8-bit) accesses, selected by BW. Storage is little-endian.
- Writes are synchronous. Reads are registered with 1-cycle latency.
- Addresses outside the RAM window are ignored on writes and return zero on reads.

Parameters:
- BASE_ADDR, 16'h0200, first byte address of the RAM window.
- SIZE_BYTES, 512, window size in bytes; must be even and a power of two; window is BASE_ADDR .. BASE_ADDR+SIZE_BYTES-1.

Ports:
- clk  input  1  system clock; all activity on the rising edge.
- rst  input  1  synchronous reset, active-high.
- BW  input  1  access size: 0 = word, 1 = byte.
- ram_RW  input  1  1 = write, 0 = read.
- ram_addr  input  16  byte address.
- ram_Din  input  16  write data.
- ram_out  output  16  registered read data.

Behaviour:
- One clock (clk). Reset is synchronous and active-high on rst.
- Reset (rst=1 at rising edge):
  - ram_out <= 16'h0000.
  - Every storage byte is cleared to 8'h00 in that same edge.
  - No write occurs that cycle; reset has priority over any access.
- In-range test: BASE_ADDR <= ram_addr <= BASE_ADDR+SIZE_BYTES-1. Offset = ram_addr - BASE_ADDR.
- Word write (ram_RW=1, BW=0, in range):
  - ram_addr[0] is ignored.
  - byte[offset&~1] <= ram_Din[7:0]; byte[offset|1] <= ram_Din[15:8].
- Byte write (ram_RW=1, BW=1, in range): byte[offset] <= ram_Din[7:0]. ram_Din[15:8] is ignored. The other byte of the word is unchanged.
- Write cycle: ram_out holds its previous value.
- Word read (ram_RW=0, BW=0):
  - In range: ram_out <= {byte[offset|1], byte[offset&~1]}.
  - Out of range: ram_out <= 0.
- Byte read (ram_RW=0, BW=1):
  - In range: ram_out <= {8'h00, byte[offset]}.
  - Out of range: ram_out <= 0.
- Read latency: data is visible after the rising edge that sampled the address, i.e. 1 cycle. A read in the cycle immediately after a write to the same address returns the new data.
- Out-of-range writes have no effect.
- Address arithmetic is 16-bit unsigned with no wrap: 16'hFFFF is out of range for the default window.
- X/Z on control inputs is not handled; behaviour is undefined.

Optional Feature:
- Macro: RAM_RANGE_CHECK_EN.
- Defined: adds output port ram_err (1 bit, registered, reset 0). ram_err is 1 for exactly the cycle after an access that is:
  - out of range, or
  - a word access with ram_addr[0]=1.
  Data behaviour is otherwise unchanged; a misaligned word access still uses the aligned word.
- Undefined: port absent; no checking logic.

Test Plan:
- Reset: hold rst=1 one edge, then word-read 16'h0200 -> ram_out=16'h0000.
- Word write then read back: write 16'hFFFF to 16'h0200 (BW=0); next cycle read -> ram_out=16'hFFFF. Write 16'h1234 to 16'h0202; read 16'h0202 -> 16'h1234; byte read 16'h0203 -> 16'h0012.
- Byte write merge: word write 16'hAAAA at 16'h0204, then byte write 16'h0055 at 16'h0205 -> word read gives 16'h55AA.
- Out of range: write 16'hBEEF to 16'h0400 and to 16'h01FE; read both -> 16'h0000; word at 16'h0200 unchanged.
- Sweep: alternate write/read every 10 time units (ram_RW toggling), ram_Din=16'hFFFF, addr stepping by 2 from 16'h0200; switch BW to 1 midway -> word reads before the switch return 16'hFFFF; byte reads after it return 16'h00FF.
- With RAM_RANGE_CHECK_EN: word read at 16'h0201 -> ram_err=1 for one cycle, ram_out = word at 16'h0200; in-range aligned access -> ram_err=0.
